// File: rtl/alu_exec_pkg.sv
// Shared types for the EX-stage execute unit: operation codes, FSM states, helpers.
// The ALU controller imports alu_op_t from here so both sides agree on the encoding.
package alu_exec_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int SHAMT_WIDTH_DEF = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_RSV9  = 4'b1001,
    ALU_RSVA  = 4'b1010,
    ALU_BEQ   = 4'b1011,
    ALU_BNE   = 4'b1100,
    ALU_BLT   = 4'b1101,
    ALU_BGE   = 4'b1110,
    ALU_PASSB = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } exec_state_t;

  function automatic logic is_shift(alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Valid/ready operand and result bus between ID/EX, the execute unit and EX/MEM.
// master drives operands and accepts results; slave is the execute unit.
interface alu_exec_unit_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  BranchTaken;
  logic                  IllegalOp;

  modport master (
    output in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, BranchTaken, IllegalOp
  );

  modport slave (
    input  in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, BranchTaken, IllegalOp
  );

endinterface

// File: rtl/alu_shift_iter.sv
// One-bit-per-cycle shifter: loads operand and amount, shifts while the counter is non-zero.
// result is the value after this cycle's shift; done flags the final step.
module alu_shift_iter
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  alu_op_t                op,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  result
);

  logic [DATA_WIDTH-1:0]  shreg_reg;
  logic [SHAMT_WIDTH-1:0] count_reg;
  alu_op_t                op_reg;
  logic                   fill;

  always_comb begin
    fill   = (op_reg == ALU_SRA) ? shreg_reg[DATA_WIDTH-1] : 1'b0;
    result = {fill, shreg_reg[DATA_WIDTH-1:1]};
    if (op_reg == ALU_SLL) begin
      result = {shreg_reg[DATA_WIDTH-2:0], 1'b0};
    end
  end

  assign busy = (count_reg != '0);
  assign done = (count_reg == SHAMT_WIDTH'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_reg <= '0;
      count_reg <= '0;
      op_reg    <= ALU_SLL;
    end else if (load) begin
      shreg_reg <= data;
      count_reg <= shamt;
      op_reg    <= op;
    end else if (busy) begin
      shreg_reg <= result;
      count_reg <= count_reg - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execute unit with valid/ready on both sides; shifts are iterative unless
// ALU_BARREL_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);

  exec_state_t           state_reg, state_next;
  logic [DATA_WIDTH-1:0] result_reg, result_next;
  logic                  branch_reg, branch_next;
  logic                  illegal_reg, illegal_next;

  alu_op_t                op;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   signed_lt;
  logic [DATA_WIDTH-1:0]  calc_result;
  logic                   calc_branch;
  logic                   calc_illegal;

  assign op        = alu_op_t'(bus.Operation);
  assign shamt     = bus.SrcB[SHAMT_WIDTH-1:0];
  assign signed_lt = ($signed(bus.SrcA) < $signed(bus.SrcB));

  // Single-cycle datapath; the iterative build only uses the shift rows for shamt = 0.
  always_comb begin
    calc_result  = '0;
    calc_branch  = 1'b0;
    calc_illegal = 1'b0;
    case (op)
      ALU_ADD:   calc_result = bus.SrcA + bus.SrcB;
      ALU_SUB:   calc_result = bus.SrcA - bus.SrcB;
      ALU_AND:   calc_result = bus.SrcA & bus.SrcB;
      ALU_OR:    calc_result = bus.SrcA | bus.SrcB;
      ALU_XOR:   calc_result = bus.SrcA ^ bus.SrcB;
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL:   calc_result = bus.SrcA << shamt;
      ALU_SRL:   calc_result = bus.SrcA >> shamt;
      ALU_SRA:   calc_result = DATA_WIDTH'($signed(bus.SrcA) >>> shamt);
`else
      ALU_SLL, ALU_SRL, ALU_SRA: calc_result = bus.SrcA;
`endif
      ALU_SLT:   calc_result = {{(DATA_WIDTH-1){1'b0}}, signed_lt};
      ALU_BEQ:   calc_branch = (bus.SrcA == bus.SrcB);
      ALU_BNE:   calc_branch = (bus.SrcA != bus.SrcB);
      ALU_BLT:   calc_branch = signed_lt;
      ALU_BGE:   calc_branch = !signed_lt;
      ALU_PASSB: calc_result = bus.SrcB;
      default:   calc_illegal = 1'b1;
    endcase
  end

`ifndef ALU_BARREL_SHIFT_EN
  logic                  shift_load;
  logic                  shift_busy;
  logic                  shift_done;
  logic [DATA_WIDTH-1:0] shift_result;

  alu_shift_iter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shift (
    .clk    (clk),
    .reset  (reset),
    .load   (shift_load),
    .op     (op),
    .data   (bus.SrcA),
    .shamt  (shamt),
    .busy   (shift_busy),
    .done   (shift_done),
    .result (shift_result)
  );
`endif

  always_comb begin
    state_next   = state_reg;
    result_next  = result_reg;
    branch_next  = branch_reg;
    illegal_next = illegal_reg;
`ifndef ALU_BARREL_SHIFT_EN
    shift_load   = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
          if (is_shift(op) && (shamt != '0)) begin
            shift_load   = 1'b1;
            branch_next  = 1'b0;
            illegal_next = 1'b0;
            state_next   = ST_SHIFT;
          end else
`endif
          begin
            result_next  = calc_result;
            branch_next  = calc_branch;
            illegal_next = calc_illegal;
            state_next   = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
`ifndef ALU_BARREL_SHIFT_EN
        if (shift_done) begin
          result_next = shift_result;
          state_next  = ST_DONE;
        end else if (!shift_busy) begin
          state_next = ST_IDLE;
        end
`else
        state_next = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      result_reg  <= '0;
      branch_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      result_reg  <= result_next;
      branch_reg  <= branch_next;
      illegal_reg <= illegal_next;
    end
  end

  assign bus.in_ready    = (state_reg == ST_IDLE);
  assign bus.out_valid   = (state_reg == ST_DONE);
  assign bus.ALUResult   = result_reg;
  assign bus.BranchTaken = branch_reg;
  assign bus.IllegalOp   = illegal_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver queues expected results, a negedge monitor
// pops and compares on each accepted output. Honours ALU_BARREL_SHIFT_EN for shift latency.
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  typedef struct packed {
    logic [31:0] res;
    logic        br;
    logic        ill;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];

  alu_exec_unit_if #(.DATA_WIDTH(32)) bus ();

  alu_exec_unit #(
    .DATA_WIDTH  (32),
    .SHAMT_WIDTH (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=0x%08h want=0x%08h", nm, act, exp);
    end
  endtask

  function automatic int shift_lat(input int n);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    return (n == 0) ? 1 : 1 + n;
`endif
  endfunction

  // Monitor: one line per retired transaction.
  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output got=0x%08h want=none", bus.ALUResult);
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        check({n, " ALUResult"}, bus.ALUResult, e.res);
        check({n, " BranchTaken"}, 32'(bus.BranchTaken), 32'(e.br));
        check({n, " IllegalOp"}, 32'(bus.IllegalOp), 32'(e.ill));
        $display("[TB] %-10s res=0x%08h br=%0b ill=%0b", n, bus.ALUResult,
                 bus.BranchTaken, bus.IllegalOp);
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eb, input logic ei,
                        input int lat, input int hold, input string nm);
    int cyc;
    exp_q.push_back('{res: er, br: eb, ill: ei});
    nm_q.push_back(nm);
    check({nm, " in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 100) begin
      check({nm, " in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      cyc++;
    end
    check({nm, " latency"}, 32'(cyc), 32'(lat));
    for (int i = 0; i < hold; i++) begin
      check({nm, " hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({nm, " hold_result"}, bus.ALUResult, er);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({nm, " retired"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.Operation = 4'd0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst ALUResult", bus.ALUResult, 32'd0);
    check("rst BranchTaken", 32'(bus.BranchTaken), 32'd0);
    check("rst IllegalOp", 32'(bus.IllegalOp), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    //     op         SrcA          SrcB          result        br    ill   latency        hold name
    run_op(ALU_ADD,   32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1,             0, "add");
    run_op(ALU_SUB,   32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1,             0, "sub_wrap");
    run_op(ALU_ADD,   32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 1'b0, 1,             0, "add_wrap");
    run_op(ALU_AND,   32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1,             0, "and");
    run_op(ALU_OR,    32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1'b0, 1,             0, "or");
    run_op(ALU_XOR,   32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1'b0, 1,             0, "xor");
    run_op(ALU_SRA,   32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, shift_lat(4),  0, "sra4");
    run_op(ALU_SLL,   32'h00001234, 32'h00000020, 32'h00001234, 1'b0, 1'b0, shift_lat(0),  0, "sll0_mask");
    run_op(ALU_SRL,   32'hF0000000, 32'd4,        32'h0F000000, 1'b0, 1'b0, shift_lat(4),  0, "srl4");
    run_op(ALU_SLL,   32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0, shift_lat(31), 0, "sll31");
    run_op(ALU_SRA,   32'h80000000, 32'h0000003F, 32'hFFFFFFFF, 1'b0, 1'b0, shift_lat(31), 0, "sra31_mask");
    run_op(ALU_SRA,   32'h40000000, 32'd30,       32'd1,        1'b0, 1'b0, shift_lat(30), 0, "sra_pos");
    run_op(ALU_BLT,   32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1,             0, "blt");
    run_op(ALU_BGE,   32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, 1,             0, "bge");
    run_op(ALU_BEQ,   32'd3,        32'd3,        32'd0,        1'b1, 1'b0, 1,             0, "beq");
    run_op(ALU_BNE,   32'd3,        32'd4,        32'd0,        1'b1, 1'b0, 1,             0, "bne");
    run_op(ALU_RSV9,  32'd5,        32'd6,        32'd0,        1'b0, 1'b1, 1,             0, "illegal9");
    run_op(ALU_RSVA,  32'd5,        32'd6,        32'd0,        1'b0, 1'b1, 1,             0, "illegalA");
    run_op(ALU_PASSB, 32'd9,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1,             0, "passb");
    run_op(ALU_SLT,   32'd0,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 1,             0, "slt_ge");
    run_op(ALU_SLT,   32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 1'b0, 1,             10, "slt_bp");

    // Reset in the middle of a long srl: nothing may come out afterwards.
    bus.Operation = ALU_SRL;
    bus.SrcA      = 32'hFFFF0000;
    bus.SrcB      = 32'd20;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midshift in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst in_ready", 32'(bus.in_ready), 32'd1);
    check("async_rst ALUResult", bus.ALUResult, 32'd0);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      check("post_rst out_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op(ALU_ADD,   32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1,             0, "add_after");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Multi-cycle execute unit that consumes the 4-bit Operation code produced by the ALU controller, plus the two operands, and returns ALUResult and a branch-taken flag.
- Sits in the EX stage between the ID/EX and EX/MEM pipeline registers.
- Uses a valid/ready handshake on both sides so the hazard unit can stall on multi-cycle shifts.
- Shifts are iterative (one bit per cycle); all other operations complete in one cycle.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- SHAMT_WIDTH, 5, shift-amount width; must equal log2(DATA_WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and Operation valid.
- in_ready  output  1  unit can accept a new operation.
- Operation  input  4  operation code (encoding under Behaviour).
- SrcA  input  DATA_WIDTH  operand A (rs1 / PC).
- SrcB  input  DATA_WIDTH  operand B (rs2 / immediate).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- ALUResult  output  DATA_WIDTH  computed result.
- BranchTaken  output  1  branch condition true (valid with out_valid).
- IllegalOp  output  1  Operation was 1001 or 1010 (valid with out_valid).

Behaviour:
- Operation encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 sll, 0110 srl, 0111 sra.
  - 1000 slt (signed).
  - 1011 beq, 1100 bne, 1101 blt (signed), 1110 bge (signed).
  - 1111 pass-B (result = SrcB).
  - 1001, 1010 illegal.
- Arithmetic and width rules:
  - add/sub wrap modulo 2^DATA_WIDTH; no overflow flag.
  - slt result is zero-extended 0 or 1.
  - Branch ops: ALUResult = 0, BranchTaken = condition. All other ops: BranchTaken = 0.
  - Illegal ops: ALUResult = 0, BranchTaken = 0, IllegalOp = 1.
- State machine: IDLE, SHIFT, DONE.
  - IDLE: in_ready = 1. On in_valid, latch Operation, SrcA and SrcB.
    - Non-shift op: compute the result, go to DONE.
    - Shift op with shamt = SrcB[SHAMT_WIDTH-1:0]: shamt = 0 loads SrcA as result and goes to DONE; shamt > 0 loads SrcA into the shift register, sets the counter to shamt, and goes to SHIFT.
  - SHIFT: each cycle shift by one bit (sll fills 0; srl fills 0; sra fills the sign bit) and decrement the counter. When the counter reaches 1, the final shift occurs and the state goes to DONE.
  - DONE: out_valid = 1. Outputs held stable until out_ready = 1, then go to IDLE.
- in_ready is 1 only in IDLE; no acceptance while busy.
- Latency, handshake cycle to out_valid: 1 cycle for non-shift ops; 1 + shamt cycles for shifts.
- Upper SrcB bits above SHAMT_WIDTH are ignored for shifts.
- out_valid may stay high indefinitely under backpressure; ALUResult, BranchTaken and IllegalOp must not change while out_valid = 1.
- Reset (asynchronous assert, synchronous deassert assumed upstream):
  - state = IDLE, in_ready = 1, out_valid = 0, ALUResult = 0, BranchTaken = 0, IllegalOp = 0, counter = 0.
  - Reset mid-SHIFT or mid-DONE discards the operation with no output.
- in_valid in a non-IDLE state is ignored; upstream must hold it until in_ready.

Optional Feature:
- ALU_BARREL_SHIFT_EN defined: shifts use a combinational barrel shifter. All ops have 1-cycle latency, and the SHIFT state is never entered (it may be removed).
- Undefined: iterative shifter as above.
- Port list is identical in both builds.

Decomposition:
- Package alu_exec_pkg:
  - typedef enum logic [3:0] alu_op_t with the names ALU_ADD … ALU_PASSB, matching the encoding above.
  - typedef enum for the FSM states.
  - Constant DATA_WIDTH_DEF = 32.
  - Function is_shift(alu_op_t).
  - The ALU controller is to import the same enum.
- Sub-module alu_shift_iter: shift register, down-counter and fill logic. Ports: load, op, data, shamt, busy, done, result. Instantiated only when ALU_BARREL_SHIFT_EN is undefined.

Test Plan:
- Reset then add: SrcA = 5, SrcB = 7, Op = 0000 -> out_valid one cycle after handshake, ALUResult = 12, BranchTaken = 0.
- sub wrap: SrcA = 0, SrcB = 1, Op = 0001 -> ALUResult = 0xFFFF_FFFF.
- sra iterative: SrcA = 0x8000_0000, SrcB = 4, Op = 0111 -> out_valid 5 cycles after handshake, ALUResult = 0xF800_0000; in_ready = 0 throughout.
- sll shamt 0 plus upper-bit masking: SrcA = 0x1234, SrcB = 0x20, Op = 0101 -> ALUResult = 0x1234 after 1 cycle.
- Branches: blt with SrcA = 0xFFFF_FFFF, SrcB = 1 -> BranchTaken = 1. bge with the same operands -> 0. beq with 3, 3 -> 1. Op = 1001 -> IllegalOp = 1, ALUResult = 0.
- Backpressure and reset:
  - out_ready held 0 for 10 cycles after slt of -1 vs 0 -> ALUResult stays 1 and out_valid stays 1.
  - reset asserted during SHIFT of srl shamt = 20 -> out_valid = 0 and in_ready = 1 immediately, with no stale result after release.
